// File: rtl/ddr3_rd_ctrl.sv
// DDR3 read-side master: turns a cache rd_start into BURST_LEN MIG read commands
// over a wrapping frame address, forwards returned beats and pulses rd_end.
module ddr3_rd_ctrl #(
  parameter int ADDR_W      = 28,
  parameter int BURST_LEN   = 64,
  parameter int ADDR_STEP   = 8,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_BEATS = 230400
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              rd_start,
  output logic              cache_wr_en,
  output logic [127:0]      rd_128bit_data,
  output logic              rd_end,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  input  logic [127:0]      app_rd_data,
  input  logic              app_rd_data_valid
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam int FR_W  = $clog2(FRAME_BEATS);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_DATA, DONE} state_t;

  state_t            state_q;
  logic              pend_q;
  logic              app_en_q;
  logic [ADDR_W-1:0] app_addr_q;
  logic              cache_wr_en_q;
  logic [127:0]      rd_data_q;
  logic              rd_end_q;
  logic [CNT_W-1:0]  cmd_cnt_q;
  logic [CNT_W-1:0]  dat_cnt_q;
  logic [FR_W-1:0]   fr_cnt_q;
  logic              in_burst;
  logic              beat_in;

  assign in_burst = (state_q == CMD) || (state_q == WAIT_DATA);
  // Beats outside CMD/WAIT_DATA are stale (e.g. after a reset) and are discarded.
  assign beat_in  = in_burst && app_rd_data_valid;

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pend_q        <= 1'b0;
      app_en_q      <= 1'b0;
      app_addr_q    <= ADDR_W'(BASE_ADDR);
      cache_wr_en_q <= 1'b0;
      rd_data_q     <= '0;
      rd_end_q      <= 1'b0;
      cmd_cnt_q     <= '0;
      dat_cnt_q     <= '0;
      fr_cnt_q      <= '0;
    end else begin
      cache_wr_en_q <= beat_in;
      if (beat_in) begin
        rd_data_q <= app_rd_data;
        dat_cnt_q <= dat_cnt_q + CNT_W'(1);
      end
      if (rd_start && (state_q != IDLE)) pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if ((rd_start || pend_q) && init_calib_complete) begin
            state_q   <= CMD;
            app_en_q  <= 1'b1;
            pend_q    <= 1'b0;
            cmd_cnt_q <= '0;
            dat_cnt_q <= '0;
          end else if (rd_start) begin
            pend_q <= 1'b1;
          end
        end
        CMD: begin
          if (app_en_q && app_rdy) begin
            cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
            if (fr_cnt_q == FR_W'(FRAME_BEATS - 1)) begin
              fr_cnt_q   <= '0;
              app_addr_q <= ADDR_W'(BASE_ADDR);
            end else begin
              fr_cnt_q   <= fr_cnt_q + FR_W'(1);
              app_addr_q <= app_addr_q + ADDR_W'(ADDR_STEP);
            end
            if (cmd_cnt_q == CNT_W'(BURST_LEN - 1)) begin
              app_en_q <= 1'b0;
              state_q  <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (dat_cnt_q == CNT_W'(BURST_LEN)) begin
            state_q  <= DONE;
            rd_end_q <= 1'b1;
          end
        end
        DONE: begin
          rd_end_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign app_cmd        = 3'b001;
  assign app_en         = app_en_q;
  assign app_addr       = app_addr_q;
  assign cache_wr_en    = cache_wr_en_q;
  assign rd_128bit_data = rd_data_q;
  assign rd_end         = rd_end_q;

endmodule

// File: tb/tb_ddr3_rd_ctrl.sv
// Directed bench for ddr3_rd_ctrl with a small-frame configuration and a
// fixed-latency MIG read model driven from the same process as the stimulus.
module tb_ddr3_rd_ctrl;
  localparam int BL  = 64;
  localparam int FB  = 100;
  localparam int LAT = 20;

  logic         sclk = 1'b0;
  logic         rst_n, calib, rd_start, app_rdy, app_rd_data_valid;
  logic [127:0] app_rd_data;
  logic         cache_wr_en, rd_end, app_en;
  logic [127:0] rd_128bit_data;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;

  ddr3_rd_ctrl #(
    .ADDR_W(28), .BURST_LEN(BL), .ADDR_STEP(8), .BASE_ADDR(0), .FRAME_BEATS(FB)
  ) dut (
    .sclk(sclk), .rst_n(rst_n), .init_calib_complete(calib), .rd_start(rd_start),
    .cache_wr_en(cache_wr_en), .rd_128bit_data(rd_128bit_data), .rd_end(rd_end),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  always #5 sclk = ~sclk;

  int           checks = 0, errors = 0, cyc = 0;
  bit           rdy_rand = 1'b0, fwd_ok = 1'b1, stray = 1'b0;
  int           due_q[$];
  logic [127:0] dat_q[$];
  int           exp_fr = 0, seq = 0;
  logic         prev_valid = 1'b0;
  logic [127:0] prev_data = '0, exp_hold = '0;
  logic         en_q = 1'b0, rdy_q = 1'b0;
  logic [27:0]  addr_q = '0, first_addr = '0, last_addr = '0;
  bit           last_beat = 1'b0, seen_end = 1'b0;
  int           beat_mod = 0, end_cyc = 0, start_cyc = 0, starts = 0;
  int           b_cmds = 0, b_beats = 0, calib_cyc = 0, end3 = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT outputs at the falling edge, then drive MIG inputs.
  task automatic tick();
    @(negedge sclk);
    cyc++;
    chk("app_cmd", app_cmd, 3'b001);
    chk("rd_end", rd_end, last_beat);
    if (rd_end) begin
      seen_end = 1'b1;
      end_cyc  = cyc;
    end
    last_beat = 1'b0;
    chk("cache_wr_en", cache_wr_en, fwd_ok && prev_valid);
    if (fwd_ok && prev_valid) exp_hold = prev_data;
    chk("rd_data", rd_128bit_data, exp_hold);
    if (en_q && !rdy_q && app_en) chk("addr_hold", app_addr, addr_q);
    if (app_en && !en_q) begin
      starts++;
      start_cyc  = cyc;
      first_addr = app_addr;
      b_cmds     = 0;
      b_beats    = 0;
    end
    if (cache_wr_en) begin
      b_beats++;
      beat_mod++;
      if (beat_mod == BL) begin
        beat_mod  = 0;
        last_beat = 1'b1;
      end
    end

    app_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (app_en && app_rdy) begin
      chk("cmd_addr", app_addr, 28'(exp_fr * 8));
      last_addr = app_addr;
      b_cmds++;
      exp_fr = (exp_fr == FB - 1) ? 0 : exp_fr + 1;
      seq++;
      due_q.push_back(cyc + LAT);
      dat_q.push_back({32'(seq), 4'h0, app_addr, 32'hD00D0000 ^ 32'(seq), ~32'(seq)});
    end
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = dat_q.pop_front();
      due_q.delete(0);
    end else begin
      app_rd_data_valid = stray;
      app_rd_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    prev_valid = app_rd_data_valid;
    prev_data  = app_rd_data;
    en_q       = app_en;
    rdy_q      = app_rdy;
    addr_q     = app_addr;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    seen_end = 1'b0;
    while (!seen_end && n < budget) begin
      tick();
      n++;
    end
    chk("burst_end_timeout", seen_end, 1'b1);
  endtask

  task automatic pulse_start();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_app_en"}, app_en, 1'b0);
    chk({tag, "_app_addr"}, app_addr, 28'd0);
    chk({tag, "_cache_wr_en"}, cache_wr_en, 1'b0);
    chk({tag, "_rd_data"}, rd_128bit_data, 128'd0);
    chk({tag, "_rd_end"}, rd_end, 1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; calib = 1'b0; rd_start = 1'b0; app_rdy = 1'b0;
    app_rd_data_valid = 1'b0; app_rd_data = '0;
    repeat (3) tick();
    chk_reset_outputs("por");
    rst_n = 1'b1;
    tick();

    // Calibration gating, then the basic burst.
    pulse_start();
    repeat (50) begin
      tick();
      chk("no_en_before_calib", app_en, 1'b0);
    end
    calib = 1'b1;
    calib_cyc = cyc;
    wait_end(400);
    chk("calib_latency", (start_cyc - calib_cyc) >= 1 && (start_cyc - calib_cyc) <= 2, 1'b1);
    chk("b1_first", first_addr, 28'd0);
    chk("b1_last", last_addr, 28'd504);
    chk("b1_cmds", b_cmds, 64);
    chk("b1_beats", b_beats, 64);

    // Backpressure, crossing the frame wrap.
    rdy_rand = 1'b1;
    tick();
    pulse_start();
    wait_end(1500);
    rdy_rand = 1'b0;
    chk("b2_first", first_addr, 28'd512);
    chk("b2_last", last_addr, 28'd216);
    chk("b2_cmds", b_cmds, 64);
    chk("b2_beats", b_beats, 64);

    // Requests during a burst and in the rd_end cycle merge into one more burst.
    pulse_start();
    repeat (30) tick();
    pulse_start();
    wait_end(400);
    end3 = end_cyc;
    chk("b3_first", first_addr, 28'd224);
    pulse_start();
    wait_end(400);
    chk("b2b_gap", start_cyc - end3, 2);
    chk("b4_first", first_addr, 28'd736);
    chk("b4_last", last_addr, 28'd440);
    repeat (100) tick();
    chk("no_extra_burst", starts, 4);

    // Reset mid-burst, then late and stray MIG data while idle.
    pulse_start();
    n = 0;
    while (b_cmds < 10 && n < 100) begin
      tick();
      n++;
    end
    chk("reset_setup_timeout", b_cmds >= 10, 1'b1);
    fwd_ok = 1'b0; exp_hold = '0; last_beat = 1'b0; beat_mod = 0;
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("mid_rst");
    tick();
    rst_n = 1'b1;
    exp_fr = 0;
    stray = 1'b1;
    repeat (40) begin
      tick();
      chk("no_en_after_reset", app_en, 1'b0);
    end
    stray = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("post_stray");
    fwd_ok = 1'b1;
    pulse_start();
    wait_end(400);
    chk("b6_first", first_addr, 28'd0);
    chk("b6_cmds", b_cmds, 64);
    chk("b6_beats", b_beats, 64);
    chk("total_starts", starts, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr3_rd_ctrl.md
Name: ddr3_rd_ctrl

Overview:
- DDR3 read-side master that answers the display cache's `rd_start` request.
- On each request it issues `BURST_LEN` read commands to the MIG user (app) interface, starting from a running frame address.
- It forwards the returned 128-bit beats as `cache_wr_en`/`rd_128bit_data`, then pulses `rd_end`.
- Sits between the MIG core and the HDMI cache controller, in the `sclk` (MIG ui_clk) domain.

Parameters:
- `ADDR_W`, 28, width of the MIG app address.
- `BURST_LEN`, 64, number of 128-bit beats returned per `rd_start`.
- `ADDR_STEP`, 8, app-address increment per 128-bit beat (16-bit DDR3 data bus, BL8).
- `BASE_ADDR`, 0, frame buffer start address.
- `FRAME_BEATS`, 230400, 128-bit beats per frame (1280x720x32 bit / 128); the address wraps after this many beats.

Ports:
- `sclk` input 1: system/MIG ui clock; all logic is rising-edge.
- `rst_n` input 1: synchronous active-low reset.
- `init_calib_complete` input 1: MIG calibration done.
- `rd_start` input 1: one-cycle read request from the cache controller.
- `cache_wr_en` output 1: valid strobe for `rd_128bit_data`.
- `rd_128bit_data` output 128: read data beat to the cache.
- `rd_end` output 1: one-cycle pulse marking that the burst is complete.
- `app_en` output 1: MIG command valid.
- `app_cmd` output 3: MIG command; constant 3'b001 (read).
- `app_addr` output ADDR_W: MIG command address.
- `app_rdy` input 1: MIG command accept.
- `app_rd_data` input 128: MIG read data.
- `app_rd_data_valid` input 1: MIG read data valid.

Behaviour:
- Reset values when `rst_n`=0 at a clock edge:
  - `app_en`=0, `app_addr`=BASE_ADDR, `cache_wr_en`=0, `rd_128bit_data`=0, `rd_end`=0.
  - FSM in IDLE; `cmd_cnt`=`dat_cnt`=0; pending=0; frame beat counter=0.
  - `app_cmd` is always 3'b001.
- FSM states: IDLE, CMD, WAIT_DATA, DONE.
- IDLE:
  - Go to CMD when (`rd_start` or pending) and `init_calib_complete`=1.
  - Clear pending on that transition; clear `cmd_cnt` and `dat_cnt`.
- CMD:
  - `app_en`=1 with `app_addr` stable until `app_rdy`=1.
  - Each cycle with `app_en`&`app_rdy` is one accepted command:
    - `cmd_cnt`++.
    - `app_addr` += ADDR_STEP.
    - Frame beat counter++.
  - When the frame beat counter reaches FRAME_BEATS-1 and that command is accepted, the next `app_addr` is BASE_ADDR and the counter returns to 0 (the wrap may fall mid-burst).
  - After the BURST_LEN-th accepted command: `app_en`=0 on the next cycle, go to WAIT_DATA.
- WAIT_DATA:
  - Stay until `dat_cnt` = BURST_LEN.
  - Data may already arrive while in CMD.
- DONE:
  - Lasts one cycle, then returns to IDLE.
- Data path (states CMD, WAIT_DATA only):
  - `cache_wr_en` <= `app_rd_data_valid`; `rd_128bit_data` <= `app_rd_data` when valid, otherwise it holds.
  - Latency is 1 cycle; `dat_cnt`++ per valid beat.
  - `app_rd_data_valid` in IDLE or DONE is dropped: no `cache_wr_en`, counters unchanged.
- `rd_end`:
  - Registered, high for exactly 1 cycle.
  - Asserted the cycle after the final (BURST_LEN-th) `cache_wr_en`, coinciding with the DONE state.
- `rd_start` while not in IDLE sets pending (single-depth; extra requests are merged).
  - The pending request is served on the IDLE entry after DONE, so CMD starts 2 cycles after `rd_end`.
  - `rd_start` in the same cycle as `rd_end` is captured as pending.
- `init_calib_complete`=0 in IDLE:
  - Stay in IDLE; `rd_start` is latched into pending.
  - A mid-burst deassertion is ignored.
- Reset mid-burst:
  - Abort immediately, all state returns to reset values.
  - Address returns to BASE_ADDR.
  - Late MIG data after reset is dropped (IDLE rule).
- Command/data counters are $clog2(BURST_LEN)+1 bits; the frame counter is $clog2(FRAME_BEATS) bits.

Test Plan:
- Basic burst:
  - Setup: calib=1, `app_rdy`=1 always, MIG model with 20-cycle read latency; pulse `rd_start`.
  - Expect: 64 `app_en` cycles with addresses 0,8,...,504; then 64 `cache_wr_en` beats, each equal to the model data 1 cycle later.
  - Expect: `rd_end` pulses once, 1 cycle after beat 64.
- Backpressure:
  - Setup: `app_rdy` random 50%.
  - Expect: `app_addr` holds whenever `app_rdy`=0; exactly 64 commands are accepted with no skipped or duplicated address; all 64 beats are forwarded.
- Frame wrap:
  - Setup: FRAME_BEATS=100, BURST_LEN=64; two `rd_start` requests.
  - Expect: the second burst's commands run 512..792 (step 8), then 0..216 (28+36 beats).
  - Expect: the third burst starts at 224.
- Back-to-back request:
  - Setup: `rd_start` during burst 1 and again in the cycle of `rd_end`.
  - Expect: exactly one extra burst, starting 2 cycles after `rd_end`; no third burst.
- Calibration gating:
  - Setup: `rd_start` pulsed with calib=0; calib rises 50 cycles later.
  - Expect: no `app_en` before calib=1; the burst starts within 2 cycles of calib=1.
- Reset and stray data:
  - Setup: `rst_n`=0 after 10 commands, then release; `app_rd_data_valid` pulses in IDLE.
  - Expect: all outputs at reset values and `cache_wr_en`=0 throughout.
  - Expect: the next `rd_start` issues addresses from BASE_ADDR=0.
